blit_data_stage: RTL and testbench

- Two-stage pipelined blitter data stage.
- Accepts source/destination byte pairs from the blitter address sequencer through a valid/ready handshake.
- Applies the 16-function logic function unit (LFU) bitwise, plus an optional transparency/collision inhibit.
- Presents write data, address and a write-enable to the memory write port.
- Sits between the read-data capture and the write-back sequencer.

---
 rtl/blit_pkg.sv | 22 ++
 rtl/blit_lfu_word.sv | 24 ++
 rtl/blit_data_stage.sv | 118 +++++++++++
 tb/tb_blit_data_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/blit_pkg.sv
// Shared definitions for the blitter data path: LFU function codes and the
// per-word control fields that travel with each source/destination pair.
package blit_pkg;

  typedef logic [3:0] lfu_code_t;

  localparam lfu_code_t LFU_ZERO   = 4'h0;
  localparam lfu_code_t LFU_COPY   = 4'hC;
  localparam lfu_code_t LFU_DEST   = 4'hA;
  localparam lfu_code_t LFU_XOR    = 4'h6;
  localparam lfu_code_t LFU_OR     = 4'hE;
  localparam lfu_code_t LFU_AND    = 4'h8;
  localparam lfu_code_t LFU_NOTSRC = 4'h3;

  // Configuration latched with every S1 word so mid-stream changes only affect later words
  typedef struct packed {
    lfu_code_t lfuc;
    logic      trans_en;
    logic      stop_en;
  } word_cfg_t;

endpackage

// File: rtl/blit_lfu_word.sv
// Combinational WIDTH-wide logic function unit with a source zero-detect
// used by the transparency inhibit.
module blit_lfu_word
  import blit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       lfuc_i,
  input  logic [WIDTH-1:0] src_i,
  input  logic [WIDTH-1:0] dst_i,
  output logic [WIDTH-1:0] result_o,
  output logic             src_zero_o
);

  // Each result bit selects one minterm enable, addressed by {src, dst}
  always_comb begin
    result_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      result_o[i] = lfuc_i[{src_i[i], dst_i[i]}];
    end
    src_zero_o = (src_i == '0);
  end

endmodule

// File: rtl/blit_data_stage.sv
// Two-stage blitter data stage: S1 captures the operand pair, S2 holds the
// LFU result, address and write-enable presented to the memory write port.
module blit_data_stage
  import blit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = 20
) (
  input  logic             MasterClock,
  input  logic             Reset,
  input  logic [3:0]       cfg_lfuc,
  input  logic             cfg_src_en,
  input  logic [WIDTH-1:0] cfg_pattern,
  input  logic             cfg_trans_en,
  input  logic             cfg_stop_on_inhibit,
  input  logic             clr_collision,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_src,
  input  logic [WIDTH-1:0] in_dst,
  input  logic [AW-1:0]    in_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_addr,
  output logic             out_we,
  output logic             collision
);

  typedef struct packed {
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] dst;
    logic [AW-1:0]    addr;
    word_cfg_t        cfg;
  } s1_word_t;

  logic             s1_v_q, s1_v_d;
  s1_word_t         s1_q, s1_d;
  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             we_q, we_d;
  logic             collision_q, collision_d;

  logic             s2_load;
  logic             accept;
  logic             inhibit;
  logic [WIDTH-1:0] lfu_result;
  logic             src_zero;

  blit_lfu_word #(.WIDTH(WIDTH)) u_lfu (
    .lfuc_i     (s1_q.cfg.lfuc),
    .src_i      (s1_q.src),
    .dst_i      (s1_q.dst),
    .result_o   (lfu_result),
    .src_zero_o (src_zero)
  );

  // in_ready looks through a draining S2 so a full pipe can stream without bubbles
  always_comb begin
    s2_load  = s1_v_q & (~s2_v_q | out_ready);
    in_ready = ~collision_q & (~s1_v_q | s2_load);
    accept   = in_valid & in_ready;
    inhibit  = s1_q.cfg.trans_en & src_zero;

    s1_v_d = accept | (s1_v_q & ~s2_load);
    s1_d   = s1_q;
    if (accept) begin
      s1_d.src          = cfg_src_en ? in_src : cfg_pattern;
      s1_d.dst          = in_dst;
      s1_d.addr         = in_addr;
      s1_d.cfg.lfuc     = cfg_lfuc;
      s1_d.cfg.trans_en = cfg_trans_en;
      s1_d.cfg.stop_en  = cfg_stop_on_inhibit;
    end

    s2_v_d = s2_load | (s2_v_q & ~out_ready);
    data_d = s2_load ? lfu_result : data_q;
    addr_d = s2_load ? s1_q.addr : addr_q;
    we_d   = s2_load ? ~inhibit : we_q;

    // Set takes priority over a simultaneous clear
    if (s2_load & inhibit & s1_q.cfg.stop_en) begin
      collision_d = 1'b1;
    end else if (clr_collision) begin
      collision_d = 1'b0;
    end else begin
      collision_d = collision_q;
    end
  end

  always_ff @(posedge MasterClock) begin
    if (Reset) begin
      s1_v_q      <= 1'b0;
      s1_q        <= '0;
      s2_v_q      <= 1'b0;
      data_q      <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_q        <= s1_d;
      s2_v_q      <= s2_v_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      collision_q <= collision_d;
    end
  end

  assign out_valid = s2_v_q;
  assign out_data  = data_q;
  assign out_addr  = addr_q;
  assign out_we    = we_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_blit_data_stage.sv
// Randomised scoreboard bench for blit_data_stage: accepted words are turned
// into expected writes by a truth-table model and compared as they leave.
module tb_blit_data_stage;
  import blit_pkg::*;

  localparam int WIDTH = 8;
  localparam int AW    = 20;

  logic             MasterClock = 1'b0;
  logic             Reset;
  logic [3:0]       cfg_lfuc;
  logic             cfg_src_en;
  logic [WIDTH-1:0] cfg_pattern;
  logic             cfg_trans_en;
  logic             cfg_stop_on_inhibit;
  logic             clr_collision;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_src;
  logic [WIDTH-1:0] in_dst;
  logic [AW-1:0]    in_addr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [AW-1:0]    out_addr;
  logic             out_we;
  logic             collision;

  logic             randomMode;
  logic             randReady;
  logic             readyForce;
  assign out_ready = randomMode ? randReady : readyForce;

  blit_data_stage #(.WIDTH(WIDTH), .AW(AW)) dut (
    .MasterClock         (MasterClock),
    .Reset               (Reset),
    .cfg_lfuc            (cfg_lfuc),
    .cfg_src_en          (cfg_src_en),
    .cfg_pattern         (cfg_pattern),
    .cfg_trans_en        (cfg_trans_en),
    .cfg_stop_on_inhibit (cfg_stop_on_inhibit),
    .clr_collision       (clr_collision),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_src              (in_src),
    .in_dst              (in_dst),
    .in_addr             (in_addr),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_data            (out_data),
    .out_addr            (out_addr),
    .out_we              (out_we),
    .collision           (collision)
  );

  always #5 MasterClock = ~MasterClock;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [AW-1:0]    addr;
    logic             we;
    logic             stopInh;
    int               acceptCycle;
  } expWord_t;

  expWord_t expQ[$];
  expWord_t frontWord;
  int       checks = 0;
  int       failures = 0;
  int       cycle = 0;
  bit       latencyCheck = 0;

  always @(posedge MasterClock) cycle <= cycle + 1;

  always @(posedge MasterClock) #1 randReady = ($urandom_range(0, 3) != 0);

  // Sum-of-minterms form of the logic function unit
  function automatic logic [WIDTH-1:0] lfuModel(input logic [3:0] l, input logic [WIDTH-1:0] s,
                                                input logic [WIDTH-1:0] d);
    return ({WIDTH{l[3]}} &  s &  d) | ({WIDTH{l[2]}} &  s & ~d) |
           ({WIDTH{l[1]}} & ~s &  d) | ({WIDTH{l[0]}} & ~s & ~d);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the head of the scoreboard against every presented word
  // and records new expected writes at each input handshake.
  always @(negedge MasterClock) begin
    if (Reset) begin
      expQ.delete();
    end else begin
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("spuriousValid", {31'b0, out_valid}, 32'd0);
        end else begin
          frontWord = expQ[0];
          checkOutput("outData", {24'b0, out_data}, {24'b0, frontWord.data});
          checkOutput("outAddr", {12'b0, out_addr}, {12'b0, frontWord.addr});
          checkOutput("outWe", {31'b0, out_we}, {31'b0, frontWord.we});
          if (out_ready) begin
            if (latencyCheck) checkOutput("latency", cycle - frontWord.acceptCycle, 32'd2);
            if (frontWord.stopInh) begin
              checkOutput("collisionSet", {31'b0, collision}, 32'd1);
              checkOutput("inReadyBlocked", {31'b0, in_ready}, 32'd0);
            end
            void'(expQ.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        automatic logic [WIDTH-1:0] srcEff = cfg_src_en ? in_src : cfg_pattern;
        automatic logic inh = cfg_trans_en && (srcEff == '0);
        expQ.push_back('{lfuModel(cfg_lfuc, srcEff, in_dst), in_addr, !inh,
                         inh && cfg_stop_on_inhibit, cycle});
      end
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] src, input logic [WIDTH-1:0] dst,
                               input logic [AW-1:0] addr, input logic [3:0] lfuc,
                               input logic srcEn, input logic [WIDTH-1:0] pattern,
                               input logic trans, input logic stop);
    bit done = 0;
    in_src = src; in_dst = dst; in_addr = addr; cfg_lfuc = lfuc;
    cfg_src_en = srcEn; cfg_pattern = pattern; cfg_trans_en = trans;
    cfg_stop_on_inhibit = stop; in_valid = 1'b1;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge MasterClock);
      if (in_ready) done = 1;
      @(posedge MasterClock); #1;
    end
    in_valid = 1'b0;
    checkOutput("acceptTimeout", {31'b0, done}, 32'd1);
  endtask

  task automatic waitDrain();
    for (int k = 0; k < 500 && (expQ.size() != 0 || out_valid); k++) begin
      @(posedge MasterClock); #1;
    end
    checkOutput("drainQueue", expQ.size(), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    automatic lfu_code_t codes[7] = '{LFU_ZERO, LFU_COPY, LFU_DEST, LFU_XOR, LFU_OR, LFU_AND, LFU_NOTSRC};
    int accepted;

    Reset = 1'b1; cfg_lfuc = '0; cfg_src_en = 1'b1; cfg_pattern = '0; cfg_trans_en = 1'b0;
    cfg_stop_on_inhibit = 1'b0; clr_collision = 1'b0; in_valid = 1'b0; in_src = '0;
    in_dst = '0; in_addr = '0; randomMode = 1'b0; readyForce = 1'b1;
    repeat (2) @(posedge MasterClock);
    @(negedge MasterClock);
    checkOutput("rstOutValid", {31'b0, out_valid}, 32'd0);
    checkOutput("rstOutWe", {31'b0, out_we}, 32'd0);
    checkOutput("rstOutData", {24'b0, out_data}, 32'd0);
    checkOutput("rstOutAddr", {12'b0, out_addr}, 32'd0);
    checkOutput("rstCollision", {31'b0, collision}, 32'd0);
    checkOutput("rstInReady", {31'b0, in_ready}, 32'd1);
    @(posedge MasterClock); #1 Reset = 1'b0;

    $display("[TB] streaming copy words");
    latencyCheck = 1;
    for (int i = 0; i < 4; i++) applyStimulus(8'h5A, 8'h0F, 20'h00100 + AW'(i), LFU_COPY, 1, 8'h00, 0, 0);
    waitDrain();
    latencyCheck = 0;

    $display("[TB] LFU sweep and pattern source");
    for (int l = 0; l < 16; l++) applyStimulus(8'hCC, 8'hAA, 20'h00200 + AW'(l), 4'(l), 1, 8'h00, 0, 0);
    applyStimulus(8'h12, 8'h00, 20'h00300, LFU_COPY, 0, 8'hF0, 0, 0);
    waitDrain();

    $display("[TB] backpressure");
    readyForce = 1'b0;
    accepted = 0;
    in_valid = 1'b1; cfg_lfuc = LFU_XOR; cfg_src_en = 1'b1; in_dst = 8'h3C;
    for (int c = 0; c < 5; c++) begin
      in_src = 8'h40 + 8'(accepted); in_addr = 20'h00400 + AW'(accepted);
      @(negedge MasterClock);
      if (in_ready) accepted++;
      @(posedge MasterClock); #1;
    end
    in_valid = 1'b0;
    checkOutput("bpAccepted", accepted, 32'd2);
    @(negedge MasterClock);
    checkOutput("bpInReadyLow", {31'b0, in_ready}, 32'd0);
    @(posedge MasterClock); #1 readyForce = 1'b1;
    for (int w = accepted; w < 3; w++) applyStimulus(8'h40 + 8'(w), 8'h3C, 20'h00400 + AW'(w), LFU_XOR, 1, 8'h00, 0, 0);
    waitDrain();

    $display("[TB] transparency collision");
    applyStimulus(8'h11, 8'h55, 20'h00500, LFU_OR, 1, 8'h00, 1, 1);
    applyStimulus(8'h00, 8'h55, 20'h00501, LFU_OR, 1, 8'h00, 1, 1);
    waitDrain();
    in_src = 8'h22; in_addr = 20'h00502; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge MasterClock);
      checkOutput("collisionHold", {31'b0, collision}, 32'd1);
      checkOutput("collisionNoAccept", {31'b0, in_ready}, 32'd0);
      @(posedge MasterClock); #1;
    end
    clr_collision = 1'b1;
    @(posedge MasterClock); #1 clr_collision = 1'b0;
    @(negedge MasterClock);
    checkOutput("collisionCleared", {31'b0, collision}, 32'd0);
    @(posedge MasterClock); #1;
    applyStimulus(8'h22, 8'h55, 20'h00502, LFU_OR, 1, 8'h00, 1, 1);
    waitDrain();

    $display("[TB] reset with full pipeline");
    readyForce = 1'b0;
    applyStimulus(8'h77, 8'h01, 20'h00600, LFU_COPY, 1, 8'h00, 0, 0);
    applyStimulus(8'h78, 8'h01, 20'h00601, LFU_COPY, 1, 8'h00, 0, 0);
    Reset = 1'b1;
    @(posedge MasterClock); #1 Reset = 1'b0;
    @(negedge MasterClock);
    checkOutput("midRstOutValid", {31'b0, out_valid}, 32'd0);
    checkOutput("midRstCollision", {31'b0, collision}, 32'd0);
    checkOutput("midRstInReady", {31'b0, in_ready}, 32'd1);
    readyForce = 1'b1;
    repeat (5) @(posedge MasterClock);
    #1;

    $display("[TB] randomised traffic");
    randomMode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      automatic logic [3:0] l = ($urandom_range(0, 1) != 0) ? codes[$urandom_range(0, 6)] : 4'($urandom);
      automatic logic [WIDTH-1:0] s = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
      automatic logic [WIDTH-1:0] p = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
      applyStimulus(s, WIDTH'($urandom), AW'($urandom), l, 1'($urandom), p, 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge MasterClock); #1;
      end
    end
    waitDrain();
    randomMode = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
